// File: rtl/cubos_pkg.sv
// Shared slot state encodings and screen geometry for the falling-square engine.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cubos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_MOVING     = 2'd1,
    ST_DONE_FONDO = 2'd2,
    ST_DONE_ATRAP = 2'd3
  } slot_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int POS_W    = 10;

endpackage

// File: rtl/cubo_slot.sv
// One falling-square slot: state machine, position/colour registers, pixel hit test.
// Latency: load/retire take effect at the next edge; hit is combinational.
// Backpressure: none; load is only asserted by the parent when this slot is IDLE.
module cubo_slot
  import cubos_pkg::*;
#(
  parameter int SIZE  = 60,
  parameter int MAX_Y = 480,
  parameter int VEL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              tick,
  input  logic [POS_W-1:0]  ld_x,
  input  logic [VEL_W-1:0]  ld_vel,
  input  logic [7:0]        ld_color,
  input  logic [VEL_W:0]    vel_eff,
  input  logic              atrapado,
  input  logic [POS_W-1:0]  pixel_x,
  input  logic [POS_W-1:0]  pixel_y,
  output slot_state_t       state,
  output logic              hit,
  output logic [POS_W-1:0]  pos_x,
  output logic [POS_W-1:0]  pos_y,
  output logic [VEL_W-1:0]  vel,
  output logic [7:0]        color
);

  // One extra bit keeps the bottom compare and the paint window free of wrap.
  localparam logic [POS_W:0] MAX_Y_W = (POS_W+1)'(MAX_Y);
  localparam logic [POS_W:0] SIZE_W  = (POS_W+1)'(SIZE);

  slot_state_t      state_q, state_d;
  logic [POS_W-1:0] pos_x_q, pos_x_d;
  logic [POS_W-1:0] pos_y_q, pos_y_d;
  logic [VEL_W-1:0] vel_q, vel_d;
  logic [7:0]       color_q, color_d;
  logic [POS_W:0]   step;

  // Next-state: catch beats bottom beats a frame step; DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    vel_d   = vel_q;
    color_d = color_q;
    step    = {1'b0, pos_y_q} + (POS_W+1)'(vel_eff);
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_MOVING;
          pos_x_d = ld_x;
          pos_y_d = '0;
          vel_d   = ld_vel;
          color_d = ld_color;
        end
      end
      ST_MOVING: begin
        if (atrapado) begin
          state_d = ST_DONE_ATRAP;
          pos_x_d = '0;
          pos_y_d = '0;
        end else if ({1'b0, pos_y_q} >= MAX_Y_W) begin
          state_d = ST_DONE_FONDO;
          pos_x_d = '0;
          pos_y_d = '0;
        end else if (tick) begin
          pos_y_d = (step > MAX_Y_W) ? MAX_Y_W[POS_W-1:0] : step[POS_W-1:0];
        end
      end
      ST_DONE_FONDO, ST_DONE_ATRAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pos_x_q <= '0;
      pos_y_q <= '0;
      vel_q   <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      vel_q   <= vel_d;
      color_q <= color_d;
    end
  end

  // Square covers columns x..x+SIZE and rows y-SIZE..y (y is the bottom edge).
  always_comb begin
    hit = (state_q == ST_MOVING) &&
          ({1'b0, pixel_x} >= {1'b0, pos_x_q}) &&
          ({1'b0, pixel_x} <= {1'b0, pos_x_q} + SIZE_W) &&
          ({1'b0, pixel_y} <= {1'b0, pos_y_q}) &&
          ({1'b0, pixel_y} + SIZE_W >= {1'b0, pos_y_q});
  end

  assign state = state_q;
  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
  assign vel   = vel_q;
  assign color = color_q;

endmodule

// File: rtl/cubos_multiples.sv
// NUM_OBJ falling squares: lowest-free-slot spawn, per-frame fall, merged paint; CUBOS_ACCEL_EN adds a global speed bonus.
// Latency: spawn/retire at next edge; start_ack, lleno and paint outputs are combinational.
// Backpressure: start is dropped (start_ack=0) while lleno=1; nothing is queued.
module cubos_multiples
  import cubos_pkg::*;
#(
  parameter int NUM_OBJ = 4,
  parameter int IDX_W   = 2,
  parameter int SIZE    = 60,
  parameter int MAX_Y   = 480,
  parameter int TICK_Y  = 481,
  parameter int VEL_W   = 2
`ifdef CUBOS_ACCEL_EN
  ,
  parameter int ACCEL_FRAMES = 600
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               pixel_x,
  input  logic [9:0]               pixel_y,
  input  logic                     start,
  input  logic [9:0]               start_x,
  input  logic [VEL_W-1:0]         start_vel,
  input  logic [7:0]               start_color,
  output logic                     start_ack,
  output logic                     lleno,
  input  logic [NUM_OBJ-1:0]       atrapado,
  output logic [NUM_OBJ-1:0]       activos,
  output logic [NUM_OBJ-1:0]       fin_fondo,
  output logic [NUM_OBJ-1:0]       fin_atrapado,
  output logic [10*NUM_OBJ-1:0]    pos_x_flat,
  output logic [10*NUM_OBJ-1:0]    pos_y_flat,
  output logic                     pintar,
  output logic [7:0]               color_out,
  output logic [IDX_W-1:0]         pintar_idx
);

  slot_state_t      st    [NUM_OBJ];
  logic             hit   [NUM_OBJ];
  logic [POS_W-1:0] px    [NUM_OBJ];
  logic [POS_W-1:0] py    [NUM_OBJ];
  logic [VEL_W-1:0] vel   [NUM_OBJ];
  logic [7:0]       col   [NUM_OBJ];
  logic [VEL_W:0]   vel_eff [NUM_OBJ];
  logic [NUM_OBJ-1:0] load;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;
  logic             tick;

  assign tick = (pixel_y == POS_W'(TICK_Y)) && (pixel_x == '0);

`ifdef CUBOS_ACCEL_EN
  localparam int CNT_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [VEL_W-1:0] bonus_q, bonus_d;

  // Frame counter wraps every ACCEL_FRAMES ticks and bumps a saturating bonus.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    bonus_d     = bonus_q;
    if (tick) begin
      if (frame_cnt_q == CNT_W'(ACCEL_FRAMES - 1)) begin
        frame_cnt_d = '0;
        if (bonus_q != '1) bonus_d = bonus_q + 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Accel registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      bonus_q     <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      bonus_q     <= bonus_d;
    end
  end
`endif

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_slot
`ifdef CUBOS_ACCEL_EN
    assign vel_eff[g] = {1'b0, vel[g]} + {1'b0, bonus_q};
`else
    assign vel_eff[g] = {1'b0, vel[g]};
`endif
    assign load[g] = start_ack && (free_idx == IDX_W'(g));

    cubo_slot #(.SIZE(SIZE), .MAX_Y(MAX_Y), .VEL_W(VEL_W)) u_slot (
      .clk      (clk),
      .rst      (reset),
      .load     (load[g]),
      .tick     (tick),
      .ld_x     (start_x),
      .ld_vel   (start_vel),
      .ld_color (start_color),
      .vel_eff  (vel_eff[g]),
      .atrapado (atrapado[g]),
      .pixel_x  (pixel_x),
      .pixel_y  (pixel_y),
      .state    (st[g]),
      .hit      (hit[g]),
      .pos_x    (px[g]),
      .pos_y    (py[g]),
      .vel      (vel[g]),
      .color    (col[g])
    );

    assign activos[g]              = (st[g] == ST_MOVING);
    assign fin_fondo[g]            = (st[g] == ST_DONE_FONDO);
    assign fin_atrapado[g]         = (st[g] == ST_DONE_ATRAP);
    assign pos_x_flat[10*g +: 10]  = px[g];
    assign pos_y_flat[10*g +: 10]  = py[g];
  end

  // Lowest-index IDLE slot takes the next spawn; DONE slots are not free yet.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (!free_found && st[i] == ST_IDLE) begin
        free_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
  end

  assign lleno     = !free_found;
  assign start_ack = start && free_found;

  // Lowest-index hitting slot owns the pixel colour.
  always_comb begin
    pintar     = 1'b0;
    color_out  = '0;
    pintar_idx = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (!pintar && hit[i]) begin
        pintar     = 1'b1;
        color_out  = col[i];
        pintar_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: tb/tb_cubos_multiples.sv
// Directed bench for cubos_multiples with a retire-event scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_cubos_multiples;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        start;
  logic [9:0]  start_x;
  logic [1:0]  start_vel;
  logic [7:0]  start_color;
  logic        start_ack, lleno;
  logic [3:0]  atrapado, activos, fin_fondo, fin_atrapado;
  logic [39:0] pos_x_flat, pos_y_flat;
  logic        pintar;
  logic [7:0]  color_out;
  logic [1:0]  pintar_idx;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  expq [$];
  logic [7:0]  mon_exp;

  cubos_multiples dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .start        (start),
    .start_x      (start_x),
    .start_vel    (start_vel),
    .start_color  (start_color),
    .start_ack    (start_ack),
    .lleno        (lleno),
    .atrapado     (atrapado),
    .activos      (activos),
    .fin_fondo    (fin_fondo),
    .fin_atrapado (fin_atrapado),
    .pos_x_flat   (pos_x_flat),
    .pos_y_flat   (pos_y_flat),
    .pintar       (pintar),
    .color_out    (color_out),
    .pintar_idx   (pintar_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] pyv(input int i);
    return pos_y_flat[10*i +: 10];
  endfunction

  function automatic logic [9:0] pxv(input int i);
    return pos_x_flat[10*i +: 10];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      pixel_x = 10'd0;
      pixel_y = 10'd481;
      cyc();
      pixel_x = 10'd700;
      pixel_y = 10'd0;
      cyc();
    end
  endtask

  task automatic spawn(input logic [9:0] x, input logic [1:0] v, input logic [7:0] c, input logic exp_ack);
    start       = 1'b1;
    start_x     = x;
    start_vel   = v;
    start_color = c;
    #1;
    chk($sformatf("start_ack x=%0d", x), start_ack, exp_ack);
    cyc();
    start = 1'b0;
  endtask

  task automatic pchk(input logic [9:0] x, input logic [9:0] y, input logic p,
                      input logic [1:0] idx, input logic [7:0] c);
    pixel_x = x;
    pixel_y = y;
    #1;
    chk($sformatf("paint(%0d,%0d) {pintar,idx,colour}", x, y), {pintar, pintar_idx, color_out}, {p, idx, c});
  endtask

  // Scoreboard monitor: every retire pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && ((fin_fondo | fin_atrapado) != 4'b0)) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_retire: got fondo=%b atrap=%b, none expected", fin_fondo, fin_atrapado);
      end else begin
        mon_exp = expq.pop_front();
        if ({fin_fondo, fin_atrapado} !== mon_exp) begin
          fails++;
          $display("FAIL retire_event: got fondo=%b atrap=%b expected fondo=%b atrap=%b",
                   fin_fondo, fin_atrapado, mon_exp[7:4], mon_exp[3:0]);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    pixel_x     = 10'd700;
    pixel_y     = 10'd0;
    start       = 1'b0;
    start_x     = '0;
    start_vel   = '0;
    start_color = '0;
    atrapado    = '0;
    repeat (2) cyc();

    // Reset state
    chk("reset activos", activos, 4'b0);
    chk("reset lleno/ack", {lleno, start_ack}, 2'b00);
    chk("reset paint", {pintar, pintar_idx, color_out}, 11'b0);
    chk("reset fins", {fin_fondo, fin_atrapado}, 8'b0);
    chk("reset pos", {pos_x_flat, pos_y_flat}, 80'b0);
    reset = 1'b0;
    cyc();

    // Asynchronous reset mid-fall
    spawn(10'd100, 2'd2, 8'hE0, 1'b1);
    chk("midfall activos", activos, 4'b0001);
    ticks(60);
    chk("midfall pos_y", pyv(0), 10'd120);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset activos", activos, 4'b0);
    chk("async reset pos", {pos_x_flat, pos_y_flat}, 80'b0);
    chk("async reset lleno", lleno, 1'b0);
    cyc();
    reset = 1'b0;
    cyc();

    // Full fall at vel=2: 240 ticks to the bottom
    spawn(10'd100, 2'd2, 8'hE0, 1'b1);
    chk("t2 activos", activos, 4'b0001);
    chk("t2 pos", {pxv(0), pyv(0)}, {10'd100, 10'd0});
    expq.push_back({4'b0001, 4'b0000});
    ticks(239);
    chk("t2 pos_y 239 ticks", pyv(0), 10'd478);
    chk("t2 still active", activos, 4'b0001);
    ticks(1);
    chk("t2 fin_fondo pulse", {fin_fondo, activos}, {4'b0001, 4'b0000});
    chk("t2 pos cleared", {pxv(0), pyv(0)}, 20'b0);
    cyc();
    chk("t2 pulse 1 cycle", {fin_fondo, activos}, 8'b0);

    // vel=3 reaches 477 then 480, retires the following cycle
    spawn(10'd0, 2'd3, 8'h03, 1'b1);
    expq.push_back({4'b0001, 4'b0000});
    ticks(159);
    chk("t3 pos_y 477", pyv(0), 10'd477);
    pixel_x = 10'd0;
    pixel_y = 10'd481;
    cyc();
    pixel_x = 10'd700;
    pixel_y = 10'd0;
    chk("t3 pos_y 480 still moving", {pyv(0), activos}, {10'd480, 4'b0001});
    cyc();
    chk("t3 fin_fondo", {fin_fondo, activos}, {4'b0001, 4'b0000});
    cyc();
    chk("t3 idle", {fin_fondo, activos}, 8'b0);

    // Fill all slots, then a dropped request
    spawn(10'd10, 2'd1, 8'h11, 1'b1);
    spawn(10'd20, 2'd1, 8'h22, 1'b1);
    spawn(10'd30, 2'd1, 8'h33, 1'b1);
    chk("t4 lleno before 4th", lleno, 1'b0);
    spawn(10'd40, 2'd1, 8'h44, 1'b1);
    chk("t4 full", {lleno, activos}, {1'b1, 4'b1111});
    spawn(10'd500, 2'd3, 8'hFF, 1'b0);
    chk("t4 drop keeps positions", pos_x_flat, {10'd40, 10'd30, 10'd20, 10'd10});
    chk("t4 drop keeps activos", activos, 4'b1111);

    // Catch slot 2, respawn into it no earlier than 2 cycles later
    atrapado = 4'b0100;
    expq.push_back({4'b0000, 4'b0100});
    cyc();
    atrapado = 4'b0000;
    chk("t4 done cycle", {fin_atrapado, activos, lleno}, {4'b0100, 4'b1011, 1'b1});
    chk("t4 slot2 pos_x cleared", pxv(2), 10'd0);
    start       = 1'b1;
    start_x     = 10'd200;
    start_vel   = 2'd1;
    start_color = 8'h55;
    #1;
    chk("t4 ack blocked in DONE", start_ack, 1'b0);
    cyc();
    chk("t4 ack after idle", {start_ack, lleno}, 2'b10);
    cyc();
    start = 1'b0;
    chk("t4 respawn activos", activos, 4'b1111);
    chk("t4 respawn slot2 x", pxv(2), 10'd200);

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();

    // Painting priority and boundaries
    spawn(10'd100, 2'd1, 8'h1C, 1'b1);
    spawn(10'd80,  2'd2, 8'hE3, 1'b1);
    ticks(10);
    pchk(10'd120, 10'd0, 1'b1, 2'd0, 8'h1C);
    pchk(10'd85,  10'd0, 1'b1, 2'd1, 8'hE3);
    ticks(40);
    chk("t5 pos_y", {pyv(0), pyv(1)}, {10'd50, 10'd100});
    pchk(10'd110, 10'd50,  1'b1, 2'd0, 8'h1C);
    pchk(10'd85,  10'd100, 1'b1, 2'd1, 8'hE3);
    pchk(10'd85,  10'd40,  1'b1, 2'd1, 8'hE3);
    pchk(10'd85,  10'd39,  1'b0, 2'd0, 8'h00);
    pchk(10'd160, 10'd50,  1'b1, 2'd0, 8'h1C);
    pchk(10'd161, 10'd50,  1'b0, 2'd0, 8'h00);
    pchk(10'd110, 10'd51,  1'b1, 2'd1, 8'hE3);

    // Catch on the same cycle as a tick at pos_y=478
    ticks(189);
    chk("t6 pos_y", {pyv(0), pyv(1)}, {10'd239, 10'd478});
    pixel_x  = 10'd0;
    pixel_y  = 10'd481;
    atrapado = 4'b0010;
    expq.push_back({4'b0000, 4'b0010});
    cyc();
    pixel_x  = 10'd700;
    pixel_y  = 10'd0;
    atrapado = 4'b0000;
    chk("t6 catch wins", {fin_fondo, fin_atrapado}, {4'b0000, 4'b0010});
    chk("t6 after catch", {pyv(1), pyv(0), activos}, {10'd0, 10'd240, 4'b0001});
    cyc();
    chk("t6 pulse 1 cycle", fin_atrapado, 4'b0);

    // Catch flags on idle slots are ignored
    atrapado = 4'b1110;
    cyc();
    atrapado = 4'b0000;
    chk("t6 idle catch ignored", {activos, fin_atrapado}, {4'b0001, 4'b0000});

    repeat (3) cyc();
    chk("scoreboard empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cubos_multiples.md
Name: cubos_multiples

Overview:
Parametrised multi-object falling-square engine, successor to the single-cube block in the Canasta game. Manages NUM_OBJ independent slots, each a square falling at its own speed, one step per video frame. New spawn requests go to the lowest free slot. Slots retire when they reach the screen bottom or when collision logic reports a catch. Merged pixel-paint and colour outputs go to the VGA mux.

Parameters:
NUM_OBJ, 4, number of object slots (1..8)
IDX_W, 2, slot index width, clog2(NUM_OBJ), minimum 1
SIZE, 60, square edge in pixels; painted extent is SIZE+1 (inclusive bounds)
MAX_Y, 480, bottom row; a slot retires when pos_y >= MAX_Y
TICK_Y, 481, pixel_y value of the frame-tick row (tick when pixel_x==0)
VEL_W, 2, per-object speed width, in pixels per frame
ACCEL_FRAMES, 600, frames per speed bonus step (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pixel_x  in  10  current scan column
pixel_y  in  10  current scan row
start  in  1  spawn request
start_x  in  10  spawn column (left edge)
start_vel  in  VEL_W  spawn speed
start_color  in  8  spawn colour
start_ack  out  1  request accepted this cycle
lleno  out  1  no free slot
atrapado  in  NUM_OBJ  per-slot catch flags from collision logic
activos  out  NUM_OBJ  slot i is in MOVING
fin_fondo  out  NUM_OBJ  1-cycle pulse: slot i reached the bottom
fin_atrapado  out  NUM_OBJ  1-cycle pulse: slot i was caught
pos_x_flat  out  10*NUM_OBJ  slot i x position at bits [10i+9:10i]
pos_y_flat  out  10*NUM_OBJ  slot i y position (bottom edge)
pintar  out  1  current pixel lies inside some active square
color_out  out  8  colour of the painting slot; 0 if none
pintar_idx  out  IDX_W  index of the painting slot

Behaviour:
- Reset (asynchronous, active-high): all slots IDLE; pos_x, pos_y, vel, colour cleared to 0. All outputs 0 except lleno=0.
- Per-slot FSM:
  - IDLE -> MOVING on load.
  - MOVING -> DONE_FONDO or DONE_ATRAP.
  - DONE_* -> IDLE after exactly 1 cycle.
  - Unused encodings -> IDLE.
- Spawn:
  - lleno = no slot in IDLE. Slots in DONE_* are not free.
  - start_ack = start && !lleno, combinational.
  - On an accepted start, the lowest-index IDLE slot loads x/vel/colour, sets pos_y=0, and enters MOVING at the next edge.
  - A request while lleno=1 is dropped; no queueing.
- Frame tick: tick = (pixel_y==TICK_Y) && (pixel_x==0), combinational.
- Movement:
  - In MOVING, on tick, pos_y <= pos_y + vel_eff, computed in 11 bits.
  - The result is clamped to MAX_Y if it exceeds MAX_Y.
  - vel_eff = vel, or vel + bonus with the optional feature.
- Retirement (checked each cycle in MOVING):
  - atrapado[i]=1 -> DONE_ATRAP. Catch has priority over bottom and over a same-cycle tick.
  - Otherwise pos_y >= MAX_Y -> DONE_FONDO.
  - On entering DONE_*: pos_x <= 0, pos_y <= 0.
  - fin_fondo[i] / fin_atrapado[i] are high exactly during the DONE_* cycle.
  - atrapado[i] is ignored in IDLE and DONE_*.
- Painting:
  - Slot i hits when: MOVING, pixel_x >= pos_x, pixel_x <= pos_x+SIZE, pixel_y <= pos_y, and pixel_y+SIZE >= pos_y.
  - All compares use 11-bit arithmetic, so there is no underflow near the top of the screen.
  - pintar = OR of all hits.
  - Lowest-index hit wins color_out and pintar_idx; both are 0 when there is no hit.
  - Painting is combinational (0-cycle latency).
- A slot in DONE_* can be re-spawned at the earliest 2 cycles after retirement.

Optional Feature:
CUBOS_ACCEL_EN:
- Defined:
  - Internal frame counter increments on tick.
  - At ACCEL_FRAMES it wraps to 0 and the bonus (VEL_W bits) increments, saturating at all-ones.
  - vel_eff = vel + bonus, using VEL_W+1 bits.
  - Reset clears both the counter and the bonus.
- Undefined: no counter is present and vel_eff = vel.

Decomposition:
- Package cubos_pkg:
  - Slot state encodings: IDLE=0, MOVING=1, DONE_FONDO=2, DONE_ATRAP=3, 2 bits.
  - Screen constants: SCREEN_W=640, SCREEN_H=480.
  - Position width constant: 10.
- Sub-module cubo_slot: one slot FSM with position registers and hit compare. It takes load, tick, vel_eff and atrapado; it outputs hit, state, pos and colour.
- The top level holds the free-slot priority encoder, the paint priority mux and the accel counter.

Test Plan:
- Reset mid-fall (slot 0 at pos_y=120) -> all outputs 0 immediately, asynchronously; activos=0.
- start with x=100, vel=2, colour=0xE0 -> start_ack=1, slot 0 MOVING next cycle; after 240 ticks, fin_fondo[0] pulses for 1 cycle and activos[0]=0.
- vel=3 from pos_y=0 -> pos_y sequence 0,3,...,477, then clamps to 480; retires on the next cycle with fin_fondo (not skipped).
- Fill all 4 slots, then start -> lleno=1, start_ack=0, request dropped. Retire slot 2, then start -> slot 2 loads, no earlier than 2 cycles after its retire pulse.
- atrapado[1] on the same cycle as a tick with pos_y=478, vel=2 -> fin_atrapado[1]=1 and fin_fondo[1]=0.
- Slots 0 and 1 overlapping at pixel (110,50) -> pintar=1, pintar_idx=0, colour of slot 0. A pixel only in slot 1 -> pintar_idx=1. With CUBOS_ACCEL_EN and ACCEL_FRAMES=2, vel=1: steps are 1,1,2,2,3,3,4,4,4.
